// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: ID-stage hazard detection and operand forwarding control.
// Tracks the destination registers of the instructions in EX/MEM/WB in a
// 3-entry scoreboard and decides, in the same cycle, whether the ID
// instruction must stall or which stage each source operand comes from.
// Optional feature macro: PIPE_HAZARD_FORWARD_EN
//   defined   -> full forwarding, only load-use in EX stalls (1 cycle)
//   undefined -> no forwarding, stall until the producer has left WB
module pipe_hazard_ctrl (
  input  logic        in_clk,
  input  logic        in_rst,
  input  logic        in_id_valid,
  input  logic [4:0]  in_id_rs_addr,
  input  logic        in_id_rs_used,
  input  logic [4:0]  in_id_rt_addr,
  input  logic        in_id_rt_used,
  input  logic [4:0]  in_id_rd_waddr,
  input  logic        in_id_rd_wena,
  input  logic        in_id_load,
  input  logic        in_flush,
  output logic        out_stall,
  output logic        out_pc_hold,
  output logic        out_ifid_hold,
  output logic [1:0]  out_fwd_a_sel,
  output logic [1:0]  out_fwd_b_sel,
  output logic [15:0] out_stall_cnt
);

  typedef struct packed {
    logic       vld;
    logic [4:0] waddr;
    logic       load;
  } sb_ent_t;

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_EX  = 2'b01;
  localparam logic [1:0] SEL_MEM = 2'b10;
  localparam logic [1:0] SEL_WB  = 2'b11;

  sb_ent_t     ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  logic       rs_chk, rt_chk;
  logic       rs_ex, rs_mem, rs_wb, rt_ex, rt_mem, rt_wb;
  logic       stall;
  logic [1:0] fwd_a, fwd_b;

  // $0 is hardwired zero, so a write to it never produces a dependency.
  function automatic logic sb_hit(input sb_ent_t e, input logic [4:0] a);
    return e.vld && (e.waddr != 5'd0) && (e.waddr == a);
  endfunction

  // Hazard detection and forwarding select from current inputs and scoreboard.
  always_comb begin
    rs_chk = in_id_valid & ~in_flush & in_id_rs_used;
    rt_chk = in_id_valid & ~in_flush & in_id_rt_used;
    rs_ex  = rs_chk & sb_hit(ex_q,  in_id_rs_addr);
    rs_mem = rs_chk & sb_hit(mem_q, in_id_rs_addr);
    rs_wb  = rs_chk & sb_hit(wb_q,  in_id_rs_addr);
    rt_ex  = rt_chk & sb_hit(ex_q,  in_id_rt_addr);
    rt_mem = rt_chk & sb_hit(mem_q, in_id_rt_addr);
    rt_wb  = rt_chk & sb_hit(wb_q,  in_id_rt_addr);
    fwd_a  = SEL_RF;
    fwd_b  = SEL_RF;
`ifdef PIPE_HAZARD_FORWARD_EN
    // Load data is not available until MEM, so only a load in EX stalls.
    stall = (rs_ex | rt_ex) & ex_q.load;
    if (!stall) begin
      // Youngest producer wins: it holds the most recent value.
      if      (rs_ex)  fwd_a = SEL_EX;
      else if (rs_mem) fwd_a = SEL_MEM;
      else if (rs_wb)  fwd_a = SEL_WB;
      if      (rt_ex)  fwd_b = SEL_EX;
      else if (rt_mem) fwd_b = SEL_MEM;
      else if (rt_wb)  fwd_b = SEL_WB;
    end
`else
    // Without bypass paths the operand must wait until the producer retires.
    stall = rs_ex | rs_mem | rs_wb | rt_ex | rt_mem | rt_wb;
`endif
  end

  // Scoreboard shift and saturating stall counter next-state.
  always_comb begin
    ex_d = '0;
    if (!stall) begin
      ex_d.vld   = in_id_valid & in_id_rd_wena & ~in_flush;
      ex_d.waddr = in_id_rd_waddr;
      ex_d.load  = in_id_load;
    end
    mem_d       = ex_q;
    wb_d        = mem_q;
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
  end

  // State registers; reset clears the scoreboard so any stall drops at once.
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      stall_cnt_q <= 16'd0;
    end else begin
      ex_q        <= ex_d;
      mem_q       <= mem_d;
      wb_q        <= wb_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign out_stall     = stall;
  assign out_pc_hold   = stall;
  assign out_ifid_hold = stall;
  assign out_fwd_a_sel = fwd_a;
  assign out_fwd_b_sel = fwd_b;
  assign out_stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: one table row per cycle, plus
// hand-written sequences for reset-mid-stall and counter saturation.
module tb_pipe_hazard_ctrl;

`ifdef PIPE_HAZARD_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        in_clk = 1'b0;
  logic        in_rst;
  logic        in_id_valid;
  logic [4:0]  in_id_rs_addr;
  logic        in_id_rs_used;
  logic [4:0]  in_id_rt_addr;
  logic        in_id_rt_used;
  logic [4:0]  in_id_rd_waddr;
  logic        in_id_rd_wena;
  logic        in_id_load;
  logic        in_flush;
  logic        out_stall;
  logic        out_pc_hold;
  logic        out_ifid_hold;
  logic [1:0]  out_fwd_a_sel;
  logic [1:0]  out_fwd_b_sel;
  logic [15:0] out_stall_cnt;

  pipe_hazard_ctrl dut (
    .in_clk(in_clk), .in_rst(in_rst),
    .in_id_valid(in_id_valid),
    .in_id_rs_addr(in_id_rs_addr), .in_id_rs_used(in_id_rs_used),
    .in_id_rt_addr(in_id_rt_addr), .in_id_rt_used(in_id_rt_used),
    .in_id_rd_waddr(in_id_rd_waddr), .in_id_rd_wena(in_id_rd_wena),
    .in_id_load(in_id_load), .in_flush(in_flush),
    .out_stall(out_stall), .out_pc_hold(out_pc_hold), .out_ifid_hold(out_ifid_hold),
    .out_fwd_a_sel(out_fwd_a_sel), .out_fwd_b_sel(out_fwd_b_sel),
    .out_stall_cnt(out_stall_cnt)
  );

  always #5 in_clk = ~in_clk;

  typedef struct {
    logic       v;
    logic [4:0] rs;
    logic       rsu;
    logic [4:0] rt;
    logic       rtu;
    logic [4:0] rd;
    logic       we;
    logic       ld;
    logic       fl;
    logic       es;
    logic [1:0] ea;
    logic [1:0] eb;
  } vec_t;

  vec_t tbl[$];
  int   n_run  = 0;
  int   n_fail = 0;

  function automatic vec_t mkv(input int v, rs, rsu, rt, rtu, rd, we, ld, fl);
    vec_t r;
    r.v  = (v != 0);   r.rs = 5'(rs); r.rsu = (rsu != 0);
    r.rt = 5'(rt);     r.rtu = (rtu != 0);
    r.rd = 5'(rd);     r.we = (we != 0); r.ld = (ld != 0); r.fl = (fl != 0);
    r.es = 1'b0;       r.ea = 2'b00;  r.eb = 2'b00;
    return r;
  endfunction

  // Expectations are given for both policies; forwarding-off never forwards.
  function automatic void add(input int v, rs, rsu, rt, rtu, rd, we, ld, fl,
                              input int off_s, on_s, on_a, on_b);
    vec_t r;
    r = mkv(v, rs, rsu, rt, rtu, rd, we, ld, fl);
    r.es = FWD ? (on_s != 0) : (off_s != 0);
    r.ea = FWD ? 2'(on_a) : 2'b00;
    r.eb = FWD ? 2'(on_b) : 2'b00;
    tbl.push_back(r);
  endfunction

  task automatic drive(input vec_t r);
    in_id_valid    = r.v;
    in_id_rs_addr  = r.rs;
    in_id_rs_used  = r.rsu;
    in_id_rt_addr  = r.rt;
    in_id_rt_used  = r.rtu;
    in_id_rd_waddr = r.rd;
    in_id_rd_wena  = r.we;
    in_id_load     = r.ld;
    in_flush       = r.fl;
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_ctl(input string nm, input logic s, input logic [1:0] a, input logic [1:0] b);
    chk({nm, " stall"},   16'(out_stall),     16'(s));
    chk({nm, " pc_hold"}, 16'(out_pc_hold),   16'(s));
    chk({nm, " ifid"},    16'(out_ifid_hold), 16'(s));
    chk({nm, " fwd_a"},   16'(out_fwd_a_sel), 16'(a));
    chk({nm, " fwd_b"},   16'(out_fwd_b_sel), 16'(b));
  endtask

  int exp_cnt;
  int cyc;

  initial begin
    in_rst = 1'b1;
    drive(mkv(1, 3, 1, 3, 1, 3, 1, 1, 0));
    #1;
    chk_ctl("in_reset", 1'b0, 2'b00, 2'b00);
    chk("in_reset cnt", out_stall_cnt, 16'd0);
    @(negedge in_clk);
    @(negedge in_clk);
    in_rst = 1'b0;
    drive(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0));
    #1;
    chk_ctl("post_reset", 1'b0, 2'b00, 2'b00);
    chk("post_reset cnt", out_stall_cnt, 16'd0);

    //  v rs u rt u rd we ld fl | off_s | on_s on_a on_b
    add(0, 0,0, 0,0,  0,0,0,0,   0,      0,0,0);   // 0 idle
    add(1, 0,0, 0,0,  7,1,0,0,   0,      0,0,0);   // 1 ALU -> $7
    add(1, 7,1, 0,0,  0,0,0,0,   1,      0,1,0);   // 2 rs=$7 in EX
    add(1, 7,1, 0,0,  0,0,0,0,   1,      0,2,0);   // 3 $7 in MEM
    add(1, 7,1, 0,0,  0,0,0,0,   1,      0,3,0);   // 4 $7 in WB
    add(1, 7,1, 0,0,  0,0,0,0,   0,      0,0,0);   // 5 clear
    add(1, 0,0, 0,0,  8,1,0,0,   0,      0,0,0);   // 6 $8 x3
    add(1, 0,0, 0,0,  8,1,0,0,   0,      0,0,0);   // 7
    add(1, 0,0, 0,0,  8,1,0,0,   0,      0,0,0);   // 8
    add(1, 8,1, 8,1,  0,0,0,0,   1,      0,1,1);   // 9 EX wins priority
    add(1, 8,1, 8,1,  0,0,0,0,   1,      0,2,2);   // 10 MEM over WB
    add(1, 8,1, 8,1,  0,0,0,0,   1,      0,3,3);   // 11 WB
    add(1, 8,1, 8,1,  0,0,0,0,   0,      0,0,0);   // 12
    add(1, 0,0, 0,0,  2,1,0,0,   0,      0,0,0);   // 13 -> $2
    add(1, 0,0, 0,0,  3,1,0,0,   0,      0,0,0);   // 14 -> $3
    add(0, 2,1, 3,1,  0,0,0,0,   0,      0,0,0);   // 15 invalid ID
    add(1, 2,1, 3,1,  0,0,0,0,   1,      0,3,2);   // 16 rs WB, rt MEM
    add(1, 2,1, 3,1,  0,0,0,0,   1,      0,0,3);   // 17
    add(1, 2,1, 3,1,  0,0,0,0,   0,      0,0,0);   // 18
    add(1, 0,0, 0,0,  4,1,0,0,   0,      0,0,0);   // 19 -> $4
    add(1, 4,0, 4,0,  0,0,0,0,   0,      0,0,0);   // 20 operands unused
    add(0, 0,0, 0,0,  0,0,0,0,   0,      0,0,0);   // 21
    add(0, 0,0, 0,0,  0,0,0,0,   0,      0,0,0);   // 22
    add(1, 0,0, 0,0,  0,1,1,0,   0,      0,0,0);   // 23 load -> $0 x3
    add(1, 0,0, 0,0,  0,1,1,0,   0,      0,0,0);   // 24
    add(1, 0,0, 0,0,  0,1,1,0,   0,      0,0,0);   // 25
    add(1, 0,1, 0,1,  0,0,0,0,   0,      0,0,0);   // 26 read $0
    add(1, 0,0, 0,0,  5,1,1,0,   0,      0,0,0);   // 27 load -> $5
    add(1, 0,0, 5,1,  0,0,0,0,   1,      1,0,0);   // 28 load-use
    add(1, 0,0, 5,1,  0,0,0,0,   1,      0,0,2);   // 29
    add(1, 0,0, 5,1,  0,0,0,0,   1,      0,0,3);   // 30
    add(1, 0,0, 5,1,  0,0,0,0,   0,      0,0,0);   // 31
    add(1, 0,0, 0,0,  6,1,1,0,   0,      0,0,0);   // 32 load -> $6
    add(1, 6,1, 0,0, 11,1,0,1,   0,      0,0,0);   // 33 flushed, wrote $11
    add(1,11,1, 0,0,  0,0,0,0,   0,      0,0,0);   // 34 EX is a bubble
    add(1, 6,1, 0,0,  0,0,0,0,   1,      0,3,0);   // 35 $6 in WB
    add(1, 6,1, 0,0,  0,0,0,0,   0,      0,0,0);   // 36

    exp_cnt = 0;
    foreach (tbl[i]) begin
      @(negedge in_clk);
      drive(tbl[i]);
      #1;
      chk_ctl($sformatf("row%0d", i), tbl[i].es, tbl[i].ea, tbl[i].eb);
      if (tbl[i].es) exp_cnt++;
    end
    @(negedge in_clk);
    drive(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0));
    #1;
    chk("table stall_cnt", out_stall_cnt, 16'(exp_cnt));

    // Reset asserted mid-stall: stall drops without a clock edge.
    @(negedge in_clk);
    drive(mkv(1, 0, 0, 0, 0, 5, 1, 1, 0));
    @(negedge in_clk);
    drive(mkv(1, 0, 0, 5, 1, 12, 1, 0, 0));
    #1;
    chk("pre_rst stall", 16'(out_stall), 16'd1);
    #1;
    in_rst = 1'b1;
    #1;
    chk_ctl("mid_rst", 1'b0, 2'b00, 2'b00);
    chk("mid_rst cnt", out_stall_cnt, 16'd0);
    @(negedge in_clk);
    in_rst = 1'b0;
    #1;
    chk_ctl("rst_release", 1'b0, 2'b00, 2'b00);
    @(negedge in_clk);
    drive(mkv(1, 12, 1, 0, 0, 0, 0, 0, 0));
    #1;
    chk_ctl("issued_after_rst", !FWD, FWD ? 2'b01 : 2'b00, 2'b00);

`ifndef PIPE_HAZARD_FORWARD_EN
    // Saturation: self-dependent instruction stalls 3 of every 4 cycles.
    @(negedge in_clk);
    in_rst = 1'b1;
    #1;
    in_rst = 1'b0;
    drive(mkv(1, 5, 1, 0, 0, 5, 1, 0, 0));
    repeat (8) @(negedge in_clk);
    chk("sat early cnt", out_stall_cnt, 16'd6);
    cyc = 0;
    while (out_stall_cnt != 16'hFFFF && cyc < 90000) begin
      @(negedge in_clk);
      cyc++;
    end
    chk("sat reached", out_stall_cnt, 16'hFFFF);
    repeat (12) @(negedge in_clk);
    chk("sat hold", out_stall_cnt, 16'hFFFF);
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
